// File: rtl/fir_pkg.sv
// Constants and the FSM state type shared by the coefficient loader and fir_core.
package fir_pkg;

    localparam int FIR_NTAPS = 64;
    localparam int FIR_CW    = 16;
    localparam int FIR_CAW   = $clog2(FIR_NTAPS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_DONE
    } fir_state_e;

endpackage

// File: rtl/fir_coeff_loader.sv
// Streams NTAPS host coefficients into the FIR core coefficient memory, then holds cload.
// Optional running checksum of accepted coefficients: define FIR_COEFF_CHECKSUM_EN.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int NTAPS       = FIR_NTAPS,
    parameter int CW          = FIR_CW,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                                   clk2,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [CW-1:0]                          s_coeff,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic                                   cload,
    output logic [((NTAPS > 1) ? $clog2(NTAPS) : 1)-1:0] caddr,
    output logic [CW-1:0]                          cin,
    output logic                                   busy,
    output logic                                   done,
    output logic [CW-1:0]                          checksum
);

    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int BW = $clog2(NTAPS + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    fir_state_e      state, state_nxt;
    logic [BW-1:0]   beat_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            beat_acc;
    logic            last_beat;
    logic            hold_end;

    // Counter bound keeps s_ready low once NTAPS beats are in, even in LOAD.
    assign s_ready   = (state == ST_LOAD) && (beat_cnt < BW'(NTAPS));
    assign beat_acc  = s_valid && s_ready;
    assign last_beat = beat_acc && (beat_cnt == BW'(NTAPS - 1));
    assign hold_end  = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign busy      = (state == ST_LOAD) || (state == ST_HOLD);
    assign done      = (state == ST_DONE);

    always_ff @(posedge clk2) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)     state_nxt = ST_LOAD;
            ST_LOAD: if (last_beat) state_nxt = ST_HOLD;
            ST_HOLD: if (hold_end)  state_nxt = ST_DONE;
            ST_DONE:                state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            beat_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            if (state == ST_IDLE && start) beat_cnt <= '0;
            else if (beat_acc)             beat_cnt <= beat_cnt + 1'b1;

            if (state == ST_HOLD) hold_cnt <= hold_cnt + 1'b1;
            else                  hold_cnt <= '0;
        end
    end

    // Write port: advances only on accepted beats, otherwise the last word is held
    // (and rewritten) until the sequence leaves HOLD.
    always_ff @(posedge clk2) begin
        if (rst) begin
            cload <= 1'b0;
            caddr <= '0;
            cin   <= '0;
        end else if (beat_acc) begin
            cload <= 1'b1;
            caddr <= beat_cnt[AW-1:0];
            cin   <= s_coeff;
        end else if (state_nxt != ST_LOAD && state_nxt != ST_HOLD) begin
            cload <= 1'b0;
            caddr <= '0;
            cin   <= '0;
        end
    end

`ifdef FIR_COEFF_CHECKSUM_EN
    logic [CW-1:0] sum_q;

    always_ff @(posedge clk2) begin
        if (rst)                            sum_q <= '0;
        else if (state == ST_IDLE && start) sum_q <= '0;
        else if (beat_acc)                  sum_q <= sum_q + s_coeff;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomised scoreboard bench for fir_coeff_loader: expected writes/checksums queued by the driver.
module tb_fir_coeff_loader;
    localparam int NTAPS       = 64;
    localparam int CW          = 16;
    localparam int HOLD_CYCLES = 4;
    localparam int AW          = 6;

    logic          clk2 = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] s_coeff = '0;
    logic          s_valid = 1'b0;
    logic          s_ready, cload, busy, done;
    logic [AW-1:0] caddr;
    logic [CW-1:0] cin, checksum;

    fir_coeff_loader #(.NTAPS(NTAPS), .CW(CW), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk2(clk2), .rst(rst), .start(start), .s_coeff(s_coeff), .s_valid(s_valid),
        .s_ready(s_ready), .cload(cload), .caddr(caddr), .cin(cin), .busy(busy),
        .done(done), .checksum(checksum)
    );

    always #5 clk2 = ~clk2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } wr_t;

    wr_t           wq[$];
    logic [CW-1:0] dq[$];
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a new write is cload rising or the address moving.
    logic          prev_cload = 1'b0;
    logic          prev_done  = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    int            hold_cnt   = 0;
    wr_t           e;
    logic [CW-1:0] exp_cs;

    always @(negedge clk2) begin
        if (!rst) begin
            if (cload && (!prev_cload || caddr != prev_addr)) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected none", caddr, cin);
                end else begin
                    e = wq.pop_front();
                    check("write_addr", 32'(caddr), 32'(e.addr));
                    check("write_data", 32'(cin), 32'(e.data));
                    check("busy_on_write", 32'(busy), 32'd1);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done 1 expected 0");
                end else begin
                    exp_cs = dq.pop_front();
                    check("checksum_at_done", 32'(checksum), 32'(exp_cs));
                    check("writes_outstanding", 32'(wq.size()), 32'd0);
                    check("hold_length", 32'(hold_cnt), 32'(HOLD_CYCLES));
                    check("done_caddr", 32'(caddr), 32'd0);
                    check("done_cin", 32'(cin), 32'd0);
                    check("done_cload", 32'(cload), 32'd0);
                    check("done_busy", 32'(busy), 32'd0);
                end
                if (prev_done) begin
                    checks++; errors++;
                    $display("FAIL done_width: got 2+ cycles expected 1");
                end
            end
        end
        hold_cnt   = (cload && caddr == AW'(NTAPS - 1)) ? hold_cnt + 1 : 0;
        prev_cload = cload;
        prev_addr  = caddr;
        prev_done  = done;
    end

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic beat(input logic [CW-1:0] v, input logic st);
        logic r;
        int   n;
        n = 0;
        s_valid = 1'b1;
        s_coeff = v;
        start   = st;
        forever begin
            @(negedge clk2);
            r = s_ready;
            tick();
            if (r) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL beat_timeout: got no s_ready expected acceptance");
                break;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    // kind: 0 ramp, 1 stall after tap 10, 2 reset after tap 30, 3 start at tap 20,
    //       4 all 0xFFFF + trailing s_valid, 5 random data with random gaps
    task automatic run_seq(input int kind);
        logic [CW-1:0] vals[NTAPS];
        logic [CW-1:0] cs;
        int            sum;
        int            n;
        wr_t           w;
        sum = 0;
        for (int k = 0; k < NTAPS; k++) begin
            if (kind == 4)      vals[k] = 16'hFFFF;
            else if (kind == 5) vals[k] = CW'($urandom);
            else                vals[k] = CW'(k + 1);
            sum += int'(vals[k]);
            w.addr = AW'(k);
            w.data = vals[k];
            wq.push_back(w);
        end
`ifdef FIR_COEFF_CHECKSUM_EN
        cs = CW'(sum);
`else
        cs = '0;
`endif
        if (kind != 2) dq.push_back(cs);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NTAPS; k++) begin
            if (kind == 1 && k == 11) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    check("stall_caddr", 32'(caddr), 32'd10);
                    check("stall_cload", 32'(cload), 32'd1);
                end
            end
            if (kind == 5 && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) tick();
            beat(vals[k], kind == 3 && k == 20);
            if (kind == 2 && k == 30) begin
                rst = 1'b1;
                tick();
                check("rst_cload", 32'(cload), 32'd0);
                check("rst_caddr", 32'(caddr), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_s_ready", 32'(s_ready), 32'd0);
                check("rst_checksum", 32'(checksum), 32'd0);
                wq.delete();
                rst = 1'b0;
                repeat (3) tick();
                return;
            end
        end
        if (kind == 4) begin
            s_valid = 1'b1;
            s_coeff = CW'($urandom);
            for (int g = 0; g < 3; g++) begin
                @(negedge clk2);
                check("s_ready_after_last", 32'(s_ready), 32'd0);
                tick();
            end
            s_valid = 1'b0;
        end
        n = 0;
        while (dq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (dq.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done pulse");
            dq.delete();
            wq.delete();
        end
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("checksum_held", 32'(checksum), 32'(cs));
        s_valid = 1'b1;
        s_coeff = CW'($urandom);
        repeat (2) tick();
        s_valid = 1'b0;
        check("checksum_after_stray", 32'(checksum), 32'(cs));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        check("reset_cload", 32'(cload), 32'd0);
        check("reset_caddr", 32'(caddr), 32'd0);
        check("reset_cin", 32'(cin), 32'd0);
        check("reset_s_ready", 32'(s_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_checksum", 32'(checksum), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        run_seq(0);
        run_seq(1);
        run_seq(2);
        run_seq(0);
        run_seq(3);
        run_seq(4);
        for (int i = 0; i < 3; i++) run_seq(5);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameter NTAPS, default 64: number of coefficient taps written per load sequence.
REQ-002 Parameter CW, default 16: coefficient width.
REQ-003 Parameter HOLD_CYCLES, default 4: number of clk2 cycles cload stays high after the last write.
REQ-004 Port clk2, input, 1: single clock (coefficient-load clock); all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port start, input, 1: one-cycle request to begin a load sequence.
REQ-007 Port s_coeff, input, CW: host coefficient data, tap 0 first.
REQ-008 Port s_valid, input, 1: s_coeff valid.
REQ-009 Port s_ready, output, 1: loader accepts s_coeff this cycle.
REQ-010 Port cload, output, 1: coefficient-memory write enable to FIR core.
REQ-011 Port caddr, output, log2(NTAPS): coefficient address to FIR core.
REQ-012 Port cin, output, CW: coefficient data to FIR core.
REQ-013 Port busy, output, 1: sequence in progress.
REQ-014 Port done, output, 1: one-cycle pulse when the sequence completes.
REQ-015 Port checksum, output, CW: checksum of loaded coefficients (see Configuration).

Function
REQ-016 FSM states IDLE, LOAD, HOLD, DONE; IDLE->LOAD on start; LOAD->HOLD on the NTAPS-th accepted beat; HOLD->DONE after HOLD_CYCLES cycles; DONE->IDLE after one cycle.
REQ-017 Beat accepted when s_valid && s_ready; s_ready = 1 only in LOAD.
REQ-018 Accepted beat k (k = 0..NTAPS-1) drives caddr = k, cin = s_coeff on the next cycle (1-cycle latency, registered outputs).
REQ-019 cload rises with the first write and stays high continuously through LOAD and HOLD; it never goes high before the first accepted beat.
REQ-020 When s_valid is low in LOAD, caddr/cin hold their last value (rewriting the same word is harmless); no address advances.
REQ-021 In HOLD, caddr/cin hold tap NTAPS-1 and cload stays high; cload falls on entry to DONE.
REQ-022 In DONE, done = 1 for exactly one cycle; caddr returns to 0, cin to 0.
REQ-023 busy = 1 in LOAD and HOLD, 0 otherwise.
REQ-024 start while busy or in DONE is ignored; start is sampled only in IDLE.
REQ-025 s_valid outside LOAD is ignored (s_ready = 0, no beat consumed).
REQ-026 Beat counter saturates at NTAPS; no write to an address >= NTAPS ever occurs.

Reset
REQ-027 rst forces IDLE; cload = 0, caddr = 0, cin = 0, s_ready = 0, busy = 0, done = 0, checksum = 0, beat counter = 0.
REQ-028 rst mid-sequence aborts immediately without a done pulse; a new start after reset restarts at tap 0.

Configuration
REQ-029 Macro FIR_COEFF_CHECKSUM_EN defined: checksum = sum mod 2^CW of all accepted s_coeff in the current sequence, cleared on start, valid when done pulses, held until the next start.
REQ-030 Macro undefined: checksum tied to 0 and no accumulator logic is present.

Structure
REQ-031 Shared package fir_pkg holds the FSM state enum, NTAPS, CW and the caddr width constant, common with fir_core.
REQ-032 No sub-module; single flat module.

Verification
REQ-033 Basic: start, then 64 back-to-back beats of values 1..64 -> cload high from first write, caddr 0..63 with cin 1..64, cload high 4 more cycles, done pulse, checksum 2080 (if enabled).
REQ-034 Stall: s_valid low 3 cycles after tap 10 -> caddr stays 10, cload stays high, sequence completes with 64 distinct writes.
REQ-035 Reset mid-load: rst after tap 30 -> next cycle cload 0, caddr 0, busy 0, no done; new start reloads from tap 0.
REQ-036 Ignored start: start pulsed during LOAD at tap 20 -> no restart, caddr continues 21, single done at end.
REQ-037 Wrap/signed: all coefficients 0xFFFF (-1) -> checksum 0xFFC0, no write to addr >= 64, extra s_valid after tap 63 not accepted (s_ready 0).
